ycr1_imem_sram_resp: RTL
========================

# ycr1_imem_sram_resp

Instruction-memory responder that terminates one router port of the core's IMEM interface, e.g. port 1. It accepts fetch requests through the req/req_ack handshake and drives a synchronous single-port SRAM macro. Each accepted request gets exactly one response: RDY_OK with data, or RDY_ER. Requests can be pipelined back-to-back, one per cycle when no wait states are configured.

## Interface
Parameters:
- YCR1_SRAM_AWIDTH, 10: SRAM word-address width. Window size is 2^(AWIDTH+2) bytes.
- YCR1_BASE_ADDR, `YCR1_IMEM_AWIDTH'h00010000: byte base of the window. Must be aligned to the window size.
- YCR1_WAIT_STATES, 0: extra response cycles beyond the SRAM read latency. Range 0..7.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  in  1  request valid.
- imem_cmd  in  1  YCR1_MEM_CMD_RD or YCR1_MEM_CMD_WR.
- imem_addr  in  `YCR1_IMEM_AWIDTH  byte address.
- imem_req_ack  out  1  ready to accept a request this cycle.
- imem_rdata  out  `YCR1_IMEM_DWIDTH  read data; valid only when imem_resp == RDY_OK.
- imem_resp  out  2  YCR1_MEM_RESP_NOTRDY / RDY_OK / RDY_ER.
- sram_cs  out  1  SRAM read strobe, one cycle per access.
- sram_addr  out  YCR1_SRAM_AWIDTH  SRAM word address, equal to imem_addr[AWIDTH+1:2].
- sram_rdata  in  `YCR1_IMEM_DWIDTH  SRAM data, valid the cycle after sram_cs.

## Operation
- Accept: a request is accepted in a cycle where imem_req & imem_req_ack are both high.
- imem_req_ack is combinational: high in IDLE, or in the BUSY cycle that issues a response. Otherwise low.
- State machine:
  - IDLE → BUSY on accept.
  - BUSY with cnt > 0: decrement cnt.
  - BUSY with cnt == 0: issue the response. Then go to BUSY with cnt = WAIT_STATES if a new request is accepted in the same cycle, otherwise go to IDLE.
- On accept: cnt loads WAIT_STATES and the err flag is latched.
- Error cases (err = 1):
  - imem_cmd == WR;
  - imem_addr[1:0] != 0;
  - imem_addr[31:AWIDTH+2] != YCR1_BASE_ADDR[31:AWIDTH+2].
- Erroneous accepts never assert sram_cs.
- sram_cs = imem_req & imem_req_ack & ~err_now, where err_now is the error condition evaluated on the current request.
- Data path:
  - WAIT_STATES == 0: imem_rdata = sram_rdata.
  - WAIT_STATES > 0: a data register captures sram_rdata in the first BUSY cycle and drives imem_rdata.
- imem_rdata is forced to 0 whenever imem_resp != RDY_OK.
- Response: imem_resp is RDY_OK or RDY_ER for exactly one cycle per accepted request, and NOTRDY in every other cycle.
- imem_req dropped before acceptance: legal; nothing is recorded.

## Timing
- Latency: request accepted at cycle T → response at T+1+WAIT_STATES.
- Throughput:
  - WAIT_STATES == 0: one request per cycle sustained.
  - WAIT_STATES == W: one request per W+1 cycles.
- Values during and after reset:
  - imem_resp = NOTRDY, imem_rdata = 0, sram_cs = 0.
  - state = IDLE, so imem_req_ack = 1. No accept takes effect while rst_n is low.
- Reset mid-operation: the pending response is dropped and no response follows. The first cycle after release is IDLE.
- Simultaneous response and new accept: both occur in the same cycle. The new access's sram_cs is asserted in that same cycle.
- Error responses are also delayed by WAIT_STATES, so latency is uniform for every request.
- Wrap-around: the highest window word (sram_addr all ones) followed by the first word outside the window → RDY_OK, then RDY_ER.

## Test plan
- WAIT_STATES=0, read at 0x00010004:
  - T: sram_cs=1, sram_addr=1.
  - T+1: resp=RDY_OK, rdata=sram[1].
- Back-to-back reads 0x00010000, 0x00010004, 0x00010008 held on consecutive cycles:
  - imem_req_ack stays 1 throughout.
  - RDY_OK with sram[0], sram[1], sram[2] on three consecutive cycles.
- Error cases, each giving RDY_ER one cycle after accept with rdata=0 and sram_cs never asserted:
  - WR cmd to 0x00010000;
  - read at 0x00010002;
  - read at 0x00020000.
- WAIT_STATES=2, read at 0x00010010:
  - req_ack low at T+1 and T+2.
  - RDY_OK at T+3 with sram[4].
  - sram_rdata changing after T+1 does not affect imem_rdata.
- Reset asserted at T+1 of a WAIT_STATES=2 access:
  - resp=NOTRDY and rdata=0 immediately.
  - No response appears after release.
  - A read at 0x00010000 then completes normally.

Source files
------------

// File: rtl/ycr1_imem_sram_resp_if.sv
// IMEM request/response bundle between a router port and an SRAM-backed responder.
// Latency: none (wires only).
// Backpressure: the master holds imem_req until imem_req_ack is seen high.
`ifndef YCR1_IMEM_AWIDTH
`define YCR1_IMEM_AWIDTH 32
`endif
`ifndef YCR1_IMEM_DWIDTH
`define YCR1_IMEM_DWIDTH 32
`endif
`ifndef YCR1_MEM_CMD_RD
`define YCR1_MEM_CMD_RD 1'b0
`endif
`ifndef YCR1_MEM_CMD_WR
`define YCR1_MEM_CMD_WR 1'b1
`endif
`ifndef YCR1_MEM_RESP_NOTRDY
`define YCR1_MEM_RESP_NOTRDY 2'b00
`endif
`ifndef YCR1_MEM_RESP_RDY_OK
`define YCR1_MEM_RESP_RDY_OK 2'b01
`endif
`ifndef YCR1_MEM_RESP_RDY_ER
`define YCR1_MEM_RESP_RDY_ER 2'b10
`endif

interface ycr1_imem_sram_resp_if;
    logic                          imem_req;
    logic                          imem_cmd;
    logic [`YCR1_IMEM_AWIDTH-1:0]  imem_addr;
    logic                          imem_req_ack;
    logic [`YCR1_IMEM_DWIDTH-1:0]  imem_rdata;
    logic [1:0]                    imem_resp;

    modport master (
        output imem_req, imem_cmd, imem_addr,
        input  imem_req_ack, imem_rdata, imem_resp
    );

    modport slave (
        input  imem_req, imem_cmd, imem_addr,
        output imem_req_ack, imem_rdata, imem_resp
    );
endinterface

// File: rtl/ycr1_imem_sram_resp.sv
// IMEM port responder backed by a synchronous single-port SRAM (read-only window).
// Latency: response 1+YCR1_WAIT_STATES cycles after accept, for OK and ER alike.
// Backpressure: req_ack high in IDLE or in the response cycle; one request per WAIT_STATES+1 cycles.
module ycr1_imem_sram_resp #(
    parameter int                            YCR1_SRAM_AWIDTH = 10,
    parameter logic [`YCR1_IMEM_AWIDTH-1:0]  YCR1_BASE_ADDR   = `YCR1_IMEM_AWIDTH'h00010000,
    parameter int                            YCR1_WAIT_STATES = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ycr1_imem_sram_resp_if.slave          imem,
    output logic                          sram_cs,
    output logic [YCR1_SRAM_AWIDTH-1:0]   sram_addr,
    input  logic [`YCR1_IMEM_DWIDTH-1:0]  sram_rdata
);

    localparam int         AW      = `YCR1_IMEM_AWIDTH;
    localparam int         DW      = `YCR1_IMEM_DWIDTH;
    localparam int         TAG_LSB = YCR1_SRAM_AWIDTH + 2;
    localparam logic [2:0] WS      = 3'(YCR1_WAIT_STATES);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state;
    logic [2:0]     cnt;
    logic           err_q;
    logic           resp_vld;
    logic           req_ack;
    logic           accept;
    logic           err_now;
    logic [DW-1:0]  rdata_src;

    // The response cycle is the last BUSY cycle; it can also take the next request.
    assign resp_vld = (state == BUSY) && (cnt == 3'd0);
    assign req_ack  = (state == IDLE) || resp_vld;
    assign accept   = imem.imem_req && req_ack;

    // Writes, misaligned words and anything outside the window are answered with RDY_ER.
    assign err_now = (imem.imem_cmd == `YCR1_MEM_CMD_WR)
                  || (imem.imem_addr[1:0] != 2'b00)
                  || (imem.imem_addr[AW-1:TAG_LSB] != YCR1_BASE_ADDR[AW-1:TAG_LSB]);

    // SRAM strobe goes out in the accept cycle; held off while in reset so nothing leaks.
    assign sram_cs   = accept && !err_now && rst_n;
    assign sram_addr = imem.imem_addr[TAG_LSB-1:2];

    assign imem.imem_req_ack = req_ack;

    // Request tracking: load wait count and error flag on accept, count down, retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            err_q <= 1'b0;
        end else if (accept) begin
            state <= BUSY;
            cnt   <= WS;
            err_q <= err_now;
        end else if (resp_vld) begin
            state <= IDLE;
        end else if (state == BUSY) begin
            cnt <= cnt - 3'd1;
        end
    end

    generate
        if (YCR1_WAIT_STATES == 0) begin : g_direct
            // SRAM output is valid exactly in the response cycle.
            assign rdata_src = sram_rdata;
        end else begin : g_hold
            logic [DW-1:0] data_q;

            // Capture SRAM output in the first BUSY cycle; the macro output may change afterwards.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if ((state == BUSY) && (cnt == WS)) begin
                    data_q <= sram_rdata;
                end
            end

            assign rdata_src = data_q;
        end
    endgenerate

    assign imem.imem_resp  = !resp_vld ? `YCR1_MEM_RESP_NOTRDY :
                             (err_q ? `YCR1_MEM_RESP_RDY_ER : `YCR1_MEM_RESP_RDY_OK);
    assign imem.imem_rdata = (resp_vld && !err_q) ? rdata_src : '0;

endmodule
